// File: rtl/pe_mac_stream.sv
// Word-serial signed multiply-accumulate PE: streams operand pairs into a preloaded wide
// accumulator and drains the result as WORD_WIDTH-bit words, with valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for start_i, addend loaded on start
//   ACCUM | accepting operand beats into the 2-stage product pipeline
//   FLUSH | pipeline draining into the accumulator
//   DRAIN | emitting result words, accumulator shifts per handshake
module pe_mac_stream #(
  parameter int WORD_WIDTH = 17,
  parameter int LAMBDA     = 2,
  parameter int ACC_WIDTH  = 48,
  parameter int OUT_WORDS  = 3
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic signed [ACC_WIDTH-1:0] c_din_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic                        in_last_i,
  input  logic signed [WORD_WIDTH:0]  a_din_i,
  input  logic signed [WORD_WIDTH:0]  b_din_i,
  input  logic                        lambda_en_i,
  input  logic                        sub_en_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [WORD_WIDTH:0]         out_dout_o,
  output logic                        out_last_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int PW = 2 * WORD_WIDTH + 2;
  localparam int CW = $clog2(OUT_WORDS + 1);
  localparam logic signed [ACC_WIDTH-1:0] LAMBDA_S = ACC_WIDTH'(LAMBDA);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;

  state_t state, state_nxt;

  logic signed [ACC_WIDTH-1:0] acc, term_q, prod_ext, scaled, term;
  logic signed [WORD_WIDTH:0]  a_q, b_q;
  logic signed [PW-1:0]        a_ext, b_ext, prod;
  logic                        lam_q, sub_q, v1, v2;
  logic [CW-1:0]               cnt;
  logic                        done_q;
  logic                        beat_ok;
  logic                        cnt_zero;

  assign cnt_zero = (cnt == '0);
  assign beat_ok  = in_valid_i && in_ready_o;
  assign busy_o   = (state != IDLE);
  assign done_o   = done_q;

  // Product is formed at full signed width, then widened before scaling so nothing is lost.
  assign a_ext    = {{(PW-WORD_WIDTH-1){a_q[WORD_WIDTH]}}, a_q};
  assign b_ext    = {{(PW-WORD_WIDTH-1){b_q[WORD_WIDTH]}}, b_q};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
  assign scaled   = lam_q ? prod_ext * LAMBDA_S : prod_ext;
  assign term     = sub_q ? -scaled : scaled;

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    out_dout_o  = '0;
    case (state)
      IDLE:  if (start_i) state_nxt = ACCUM;
      ACCUM: begin
        in_ready_o = 1'b1;
        if (in_valid_i && in_last_i) state_nxt = FLUSH;
      end
      FLUSH: if (cnt_zero) state_nxt = DRAIN;
      DRAIN: begin
        out_valid_o = 1'b1;
        out_last_o  = cnt_zero;
        out_dout_o  = cnt_zero ? acc[WORD_WIDTH:0] : {1'b0, acc[WORD_WIDTH-1:0]};
        if (out_ready_i && cnt_zero) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      acc    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      lam_q  <= 1'b0;
      sub_q  <= 1'b0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      term_q <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      v1 <= beat_ok;
      if (beat_ok) begin
        a_q   <= a_din_i;
        b_q   <= b_din_i;
        lam_q <= lambda_en_i;
        sub_q <= sub_en_i;
      end
      v2     <= v1;
      term_q <= term;
      done_q <= (state == DRAIN) && out_ready_i && cnt_zero;
      // cnt is the flush timer in FLUSH and the remaining-word count in DRAIN.
      case (state)
        IDLE: if (start_i) acc <= c_din_i;
        ACCUM: begin
          cnt <= CW'(1);
          if (v2) acc <= acc + term_q;
        end
        FLUSH: begin
          cnt <= cnt_zero ? CW'(OUT_WORDS - 1) : cnt - 1'b1;
          if (v2) acc <= acc + term_q;
        end
        DRAIN: begin
          if (out_ready_i && !cnt_zero) begin
            cnt <= cnt - 1'b1;
            acc <= acc >>> WORD_WIDTH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_stream.sv
// Bench for pe_mac_stream: directed and random jobs checked against an arithmetic model
// of the accumulated value and its word decomposition.
module tb_pe_mac_stream;
  localparam int WW  = 17;
  localparam int LAM = 2;
  localparam int AW  = 48;
  localparam int OW  = 3;

  logic                 clock_i = 1'b0;
  logic                 reset_i = 1'b1;
  logic                 start_i = 1'b0;
  logic signed [AW-1:0] c_din_i = '0;
  logic                 in_valid_i = 1'b0;
  logic                 in_ready_o;
  logic                 in_last_i = 1'b0;
  logic signed [WW:0]   a_din_i = '0;
  logic signed [WW:0]   b_din_i = '0;
  logic                 lambda_en_i = 1'b0;
  logic                 sub_en_i = 1'b0;
  logic                 out_valid_o;
  logic                 out_ready_i = 1'b1;
  logic [WW:0]          out_dout_o;
  logic                 out_last_o;
  logic                 busy_o;
  logic                 done_o;

  pe_mac_stream #(.WORD_WIDTH(WW), .LAMBDA(LAM), .ACC_WIDTH(AW), .OUT_WORDS(OW)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .c_din_i(c_din_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_last_i(in_last_i),
    .a_din_i(a_din_i), .b_din_i(b_din_i), .lambda_en_i(lambda_en_i), .sub_en_i(sub_en_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_dout_o(out_dout_o),
    .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clock_i = ~clock_i;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int jobs_done = 0;

  always @(posedge clock_i) if (done_o === 1'b1) done_seen++;

  // current job's beats
  int               nbeats;
  logic signed [WW:0] ba[8];
  logic signed [WW:0] bb[8];
  bit               bl[8];
  bit               bs[8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_in_ready"},  64'(in_ready_o),  0);
    check({tag, "_out_valid"}, 64'(out_valid_o), 0);
    check({tag, "_dout"},      64'(out_dout_o),  0);
    check({tag, "_last"},      64'(out_last_o),  0);
    check({tag, "_busy"},      64'(busy_o),      0);
    check({tag, "_done"},      64'(done_o),      0);
  endtask

  task automatic set_beat(input int i, input int a, input int b, input bit l, input bit s);
    ba[i] = 18'(a);
    bb[i] = 18'(b);
    bl[i] = l;
    bs[i] = s;
  endtask

  // Called at a negedge; the start is presented in the current cycle.
  task automatic run_job(input logic [AW-1:0] c, input int gap, input int stall_word,
                         input int stall_len, input bit junk);
    longint      acc_m, t, v;
    logic [WW:0] exp_w[OW];
    int          k;
    acc_m = longint'($signed(c));
    for (int i = 0; i < nbeats; i++) begin
      t = longint'(ba[i]) * longint'(bb[i]);
      if (bl[i]) t = t * LAM;
      if (bs[i]) t = -t;
      acc_m = acc_m + t;
    end
    v = (acc_m <<< (64 - AW)) >>> (64 - AW);
    for (int w = 0; w < OW - 1; w++) begin
      exp_w[w] = {1'b0, v[WW-1:0]};
      v = v >>> WW;
    end
    exp_w[OW-1] = v[WW:0];

    start_i = 1'b1;
    c_din_i = c;
    out_ready_i = 1'b1;
    @(posedge clock_i);
    @(negedge clock_i);
    start_i = 1'b0;
    check("busy_after_start", 64'(busy_o), 1);
    check("ready_after_start", 64'(in_ready_o), 1);

    for (int i = 0; i < nbeats; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid_i = 1'b0;
        a_din_i = 18'($urandom);
        @(negedge clock_i);
      end
      in_valid_i  = 1'b1;
      a_din_i     = ba[i];
      b_din_i     = bb[i];
      lambda_en_i = bl[i];
      sub_en_i    = bs[i];
      in_last_i   = (i == nbeats - 1);
      @(posedge clock_i);
      @(negedge clock_i);
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
    end

    check("ready_low_after_last", 64'(in_ready_o), 0);
    if (junk) begin
      in_valid_i = 1'b1;
      a_din_i    = 18'($urandom);
      b_din_i    = 18'($urandom);
      start_i    = 1'b1;
    end
    k = 1;
    while (out_valid_o !== 1'b1 && k < 10) begin
      @(negedge clock_i);
      k++;
    end
    check("first_valid_latency", 64'(k), 3);

    for (int w = 0; w < OW; w++) begin
      if (w == stall_word) begin
        out_ready_i = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check("stall_valid", 64'(out_valid_o), 1);
          check("stall_word", 64'(out_dout_o), 64'(exp_w[w]));
          check("stall_last", 64'(out_last_o), 64'(w == OW - 1));
          @(negedge clock_i);
        end
        out_ready_i = 1'b1;
      end
      check("word_valid", 64'(out_valid_o), 1);
      check($sformatf("word%0d", w), 64'(out_dout_o), 64'(exp_w[w]));
      check("word_last", 64'(out_last_o), 64'(w == OW - 1));
      @(posedge clock_i);
      @(negedge clock_i);
    end
    check("done_pulse", 64'(done_o), 1);
    check("busy_after_done", 64'(busy_o), 0);
    check("valid_after_done", 64'(out_valid_o), 0);
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    jobs_done++;
  endtask

  task automatic load_scn1();
    nbeats = 2;
    set_beat(0, 3, 5, 1'b0, 1'b0);
    set_beat(1, -2, 7, 1'b1, 1'b0);
  endtask

  task automatic load_scn2();
    nbeats = 1;
    set_beat(0, 4, 6, 1'b0, 1'b1);
  endtask

  function automatic int pick_op();
    case ($urandom_range(0, 4))
      0: return -131072;
      1: return 131071;
      default: return int'($urandom_range(0, 262143)) - 131072;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clock_i);
    check_all_low("reset");
    reset_i = 1'b0;
    @(negedge clock_i);
    check_all_low("idle");

    load_scn1();
    run_job(48'd0, 0, -1, 0, 1'b0);
    load_scn2();
    run_job(48'd100, 0, -1, 0, 1'b0);
    nbeats = 1;
    set_beat(0, 'h1FFFF, 'h1FFFF, 1'b1, 1'b0);
    run_job(48'd0, 0, -1, 0, 1'b0);
    load_scn1();
    run_job(48'd0, 0, 1, 5, 1'b0);
    load_scn1();
    run_job(48'd0, 3, -1, 0, 1'b0);

    // reset in the middle of accumulation
    start_i = 1'b1;
    c_din_i = 48'h123456789AB;
    @(posedge clock_i);
    @(negedge clock_i);
    start_i     = 1'b0;
    in_valid_i  = 1'b1;
    a_din_i     = 18'sd1000;
    b_din_i     = 18'sd1000;
    lambda_en_i = 1'b1;
    sub_en_i    = 1'b0;
    in_last_i   = 1'b0;
    @(posedge clock_i);
    @(negedge clock_i);
    in_valid_i = 1'b0;
    reset_i    = 1'b1;
    @(posedge clock_i);
    @(negedge clock_i);
    check_all_low("midreset");
    reset_i = 1'b0;
    @(negedge clock_i);
    load_scn2();
    run_job(48'd100, 0, -1, 0, 1'b0);

    for (int j = 0; j < 25; j++) begin
      nbeats = $urandom_range(1, 6);
      for (int i = 0; i < nbeats; i++)
        set_beat(i, pick_op(), pick_op(), 1'($urandom), 1'($urandom));
      run_job(48'({$urandom, $urandom}), $urandom_range(0, 2),
              $urandom_range(0, OW), $urandom_range(1, 4), 1'($urandom));
    end

    repeat (3) @(negedge clock_i);
    check("done_pulse_count", 64'(done_seen), 64'(jobs_done));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
